// File: rtl/io881_regfile.sv
// rtl/io881_regfile.sv - io881 programmer-visible register file (A, B, X, Y)
//
// Purpose: holds accumulators A/B (8-bit) and index registers X/Y (16-bit).
// X/Y support byte loads, word loads and increment/decrement. Zero flags
// xz/yz are registered from the next-state index value.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   d8, d16             byte / word write-back data
//   wea, web            load d8 into A / B
//   wexl, wexh, wex16   load X low byte / high byte / full word
//   incx, decx          X increment / decrement
//   weyl, weyh, wey16   load Y low byte / high byte / full word
//   incy, decy          Y increment / decrement
//   qa, qb, qx, qy      current register contents
//   xz, yz              registered X==0 / Y==0 flags
module io881_regfile #(
   parameter logic [7:0]  RESET_A   = 8'h00,
   parameter logic [7:0]  RESET_B   = 8'h00,
   parameter logic [15:0] RESET_IDX = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  d8,
   input  logic [15:0] d16,
   input  logic        wea,
   input  logic        web,
   input  logic        wexl,
   input  logic        wexh,
   input  logic        wex16,
   input  logic        incx,
   input  logic        decx,
   input  logic        weyl,
   input  logic        weyh,
   input  logic        wey16,
   input  logic        incy,
   input  logic        decy,
   output logic [7:0]  qa,
   output logic [7:0]  qb,
   output logic [15:0] qx,
   output logic [15:0] qy,
   output logic        xz,
   output logic        yz
);

   // Strobes that are anything other than a clean 1 (X/Z after reset) are
   // treated as inactive so unknown control cannot corrupt state.
   logic s_wea, s_web;
   logic s_wexl, s_wexh, s_wex16, s_incx, s_decx;
   logic s_weyl, s_weyh, s_wey16, s_incy, s_decy;

   assign s_wea   = (wea   === 1'b1);
   assign s_web   = (web   === 1'b1);
   assign s_wexl  = (wexl  === 1'b1);
   assign s_wexh  = (wexh  === 1'b1);
   assign s_wex16 = (wex16 === 1'b1);
   assign s_incx  = (incx  === 1'b1);
   assign s_decx  = (decx  === 1'b1);
   assign s_weyl  = (weyl  === 1'b1);
   assign s_weyh  = (weyh  === 1'b1);
   assign s_wey16 = (wey16 === 1'b1);
   assign s_incy  = (incy  === 1'b1);
   assign s_decy  = (decy  === 1'b1);

   logic [7:0]  a_r, b_r;
   logic [15:0] x_r, y_r;
   logic [15:0] x_nxt, y_nxt;
   logic        xz_r, yz_r;

   // Shared update rule for X and Y: word load beats byte loads, byte loads
   // beat inc/dec, and inc together with dec cancels out.
   function automatic logic [15:0] idx_next(
      input logic [15:0] cur,
      input logic [15:0] w_data,
      input logic [7:0]  b_data,
      input logic        w16,
      input logic        wl,
      input logic        wh,
      input logic        inc,
      input logic        dec
   );
      logic [15:0] n;
      n = cur;
      if (w16) begin
         n = w_data;
      end else if (wl || wh) begin
         if (wl) n[7:0]  = b_data;
         if (wh) n[15:8] = b_data;
      end else if (inc && !dec) begin
         n = cur + 16'd1;
      end else if (dec && !inc) begin
         n = cur - 16'd1;
      end
      return n;
   endfunction

   always_comb begin
      x_nxt = idx_next(x_r, d16, d8, s_wex16, s_wexl, s_wexh, s_incx, s_decx);
      y_nxt = idx_next(y_r, d16, d8, s_wey16, s_weyl, s_weyh, s_incy, s_decy);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r <= RESET_A;
         b_r <= RESET_B;
      end else begin
         if (s_wea) a_r <= d8;
         if (s_web) b_r <= d8;
      end
   end

   // Flags are computed from the next-state value so they change on the
   // same edge as the register they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_r  <= RESET_IDX;
         y_r  <= RESET_IDX;
         xz_r <= (RESET_IDX == 16'h0000);
         yz_r <= (RESET_IDX == 16'h0000);
      end else begin
         x_r  <= x_nxt;
         y_r  <= y_nxt;
         xz_r <= (x_nxt == 16'h0000);
         yz_r <= (y_nxt == 16'h0000);
      end
   end

   assign qa = a_r;
   assign qb = b_r;
   assign qx = x_r;
   assign qy = y_r;
   assign xz = xz_r;
   assign yz = yz_r;

endmodule
